// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer
// Description : Launches the shared multiplier/divider, waits for completion
//               under a watchdog, commits HI/LO and raises div0/timeout pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
    parameter int TIMEOUT_CYCLES = 40,
    parameter int CNT_W          = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] operand_b,
    input  logic        eng_done,
    input  logic        hilo_read_req,
    output logic        mult_start,
    output logic        div_start,
    output logic        mult_div_sel,
    output logic        hi_write,
    output logic        lo_write,
    output logic        busy,
    output logic        done,
    output logic        div0_exc,
    output logic        timeout_exc,
    output logic        stall
);

    localparam logic [2:0] c_idle     = 3'd0;
    localparam logic [2:0] c_launch   = 3'd1;
    localparam logic [2:0] c_wait     = 3'd2;
    localparam logic [2:0] c_write    = 3'd3;
    localparam logic [2:0] c_done     = 3'd4;
    localparam logic [2:0] c_exc_div0 = 3'd5;
    localparam logic [2:0] c_exc_to   = 3'd6;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sel;
    logic             w_div0;

    assign w_div0 = op && (operand_b == 32'd0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= c_idle;
            r_cnt   <= '0;
            r_sel   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == c_launch) begin
                r_cnt <= '0;
            end else if ((r_state == c_wait) && !eng_done && (r_cnt != c_cnt_last)) begin
                r_cnt <= r_cnt + c_cnt_one;
            end
            // Source select only changes on an accepted, non-faulting request.
            if ((r_state == c_idle) && start && !w_div0) begin
                r_sel <= op;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle: begin
                if (start) begin
                    w_next_state = w_div0 ? c_exc_div0 : c_launch;
                end
            end
            c_launch: w_next_state = c_wait;
            c_wait: begin
                // Completion wins over the watchdog on the same cycle.
                if (eng_done) begin
                    w_next_state = c_write;
                end else if (r_cnt == c_cnt_last) begin
                    w_next_state = c_exc_to;
                end
            end
            c_write:    w_next_state = c_done;
            c_done:     w_next_state = c_idle;
            c_exc_div0: w_next_state = c_idle;
            c_exc_to:   w_next_state = c_idle;
            default:    w_next_state = c_idle;
        endcase
    end

    assign mult_start   = (r_state == c_launch) && !r_sel;
    assign div_start    = (r_state == c_launch) &&  r_sel;
    assign mult_div_sel = r_sel;
    assign hi_write     = (r_state == c_write);
    assign lo_write     = (r_state == c_write);
    assign busy         = (r_state != c_idle);
    assign done         = (r_state == c_done);
    assign div0_exc     = (r_state == c_exc_div0);
    assign timeout_exc  = (r_state == c_exc_to);
    // DONE is excluded: HI/LO already hold the committed result there.
    assign stall        = hilo_read_req &&
                          ((r_state == c_launch) || (r_state == c_wait) || (r_state == c_write));

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_sequencer
// Description : Scoreboard bench: expected output events are queued at issue
//               time and matched by a monitor as the sequencer produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

    localparam int c_k_mst  = 0;
    localparam int c_k_dst  = 1;
    localparam int c_k_wr   = 2;
    localparam int c_k_badw = 3;
    localparam int c_k_done = 4;
    localparam int c_k_div0 = 5;
    localparam int c_k_to   = 6;
    localparam int c_k_idle = 7;

    typedef struct {
        int   kind;
        int   cyc;
        logic sel;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] operand_b = 32'd0;
    logic        eng_done = 1'b0;
    logic        hilo_read_req = 1'b0;
    logic        mult_start, div_start, mult_div_sel, hi_write, lo_write;
    logic        busy, done, div0_exc, timeout_exc, stall;

    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    int   eng_lat = -1;
    int   eng_due = -1;
    int   stall_lo = 1;
    int   stall_hi = 0;
    logic prev_busy = 1'b0;
    exp_t sb[$];

    muldiv_sequencer #(.TIMEOUT_CYCLES(40), .CNT_W(6)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .operand_b(operand_b),
        .eng_done(eng_done), .hilo_read_req(hilo_read_req),
        .mult_start(mult_start), .div_start(div_start), .mult_div_sel(mult_div_sel),
        .hi_write(hi_write), .lo_write(lo_write), .busy(busy), .done(done),
        .div0_exc(div0_exc), .timeout_exc(timeout_exc), .stall(stall)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            c_k_mst:  return "mult_start";
            c_k_dst:  return "div_start";
            c_k_wr:   return "hilo_write";
            c_k_badw: return "partial_hilo_write";
            c_k_done: return "done";
            c_k_div0: return "div0_exc";
            c_k_to:   return "timeout_exc";
            default:  return "busy_fall";
        endcase
    endfunction

    task automatic push(input int kind, input int c, input logic sel);
        exp_t e;
        e.kind = kind; e.cyc = c; e.sel = sel;
        sb.push_back(e);
    endtask

    task automatic observe(input int kind);
        exp_t e;
        compared++;
        if (sb.size() == 0) begin
            mismatched++;
            $display("FAIL event: got %s at cycle %0d, expected no event", kname(kind), cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.cyc != cyc || (kind == c_k_wr && e.sel != mult_div_sel)) begin
                mismatched++;
                $display("FAIL event: got %s at cycle %0d sel=%0b, expected %s at cycle %0d sel=%0b",
                         kname(kind), cyc, mult_div_sel, kname(e.kind), e.cyc, e.sel);
            end
        end
    endtask

    // Engine model: completion N cycles after the start pulse it saw.
    always @(negedge clock) begin
        if ((mult_start || div_start) && eng_lat >= 0) eng_due = cyc + eng_lat;
        eng_done = (cyc == eng_due);
    end

    // Monitor: sampled 1 time unit after the falling edge.
    always @(negedge clock) begin
        #1;
        if (mult_start) observe(c_k_mst);
        if (div_start) observe(c_k_dst);
        if (hi_write || lo_write) observe((hi_write && lo_write) ? c_k_wr : c_k_badw);
        if (done) observe(c_k_done);
        if (div0_exc) observe(c_k_div0);
        if (timeout_exc) observe(c_k_to);
        if (prev_busy && !busy) observe(c_k_idle);
        prev_busy = busy;
        compared++;
        if (stall !== (hilo_read_req && cyc >= stall_lo && cyc <= stall_hi)) begin
            mismatched++;
            $display("FAIL stall: got %0b at cycle %0d, expected %0b", stall, cyc,
                     hilo_read_req && cyc >= stall_lo && cyc <= stall_hi);
        end
    end

    task automatic run_until(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    task automatic check_all_zero(input string name);
        compared++;
        if ({mult_start, div_start, mult_div_sel, hi_write, lo_write, busy, done,
             div0_exc, timeout_exc, stall} !== 10'd0) begin
            mismatched++;
            $display("FAIL %s: outputs=%b, expected all zero", name,
                     {mult_start, div_start, mult_div_sel, hi_write, lo_write, busy, done,
                      div0_exc, timeout_exc, stall});
        end
    endtask

    // Issue one request at a falling edge; base is the edge that samples start,
    // and spec cycle c is observed while cyc == base + c - 1.
    task automatic issue(input logic o, input logic [31:0] b, input int lat,
                         input logic hilo, input logic mid_start);
        int base, last;
        base = cyc + 1;
        start = 1'b1; op = o; operand_b = b; eng_lat = lat;
        if (o && b == 32'd0) begin
            push(c_k_div0, base, 1'b0);
            push(c_k_idle, base + 1, 1'b0);
            stall_lo = 1; stall_hi = 0;
            last = base + 1;
        end else if (lat < 0 || lat > 40) begin
            push(o ? c_k_dst : c_k_mst, base, o);
            push(c_k_to, base + 41, o);
            push(c_k_idle, base + 42, o);
            stall_lo = base; stall_hi = base + 40;
            last = base + 42;
        end else begin
            push(o ? c_k_dst : c_k_mst, base, o);
            push(c_k_wr, base + lat + 1, o);
            push(c_k_done, base + lat + 2, o);
            push(c_k_idle, base + lat + 3, o);
            stall_lo = base; stall_hi = base + lat + 1;
            last = base + lat + 3;
        end
        hilo_read_req = hilo;
        @(negedge clock);
        start = 1'b0;
        if (mid_start) begin
            run_until(base + 9);
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
        end
        run_until(last + 1);
        hilo_read_req = 1'b0;
        eng_lat = -1;
        run_until(last + 3);
    endtask

    initial begin : stim
        int base;
        #1;
        check_all_zero("reset_state");
        repeat (2) @(negedge clock);
        #2 reset = 1'b1;
        @(negedge clock);

        issue(1'b0, 32'd5, 32, 1'b0, 1'b0);            // MULT, nominal
        issue(1'b1, 32'h0000_0007, 33, 1'b0, 1'b0);    // DIV, nominal
        issue(1'b1, 32'd0, 33, 1'b0, 1'b0);            // DIV by zero
        issue(1'b0, 32'd5, -1, 1'b0, 1'b0);            // MULT, engine hangs
        issue(1'b0, 32'd5, 40, 1'b0, 1'b0);            // done on final WAIT cycle
        issue(1'b0, 32'd11, 32, 1'b1, 1'b1);           // stall + ignored restart

        // Reset in mid-WAIT of a DIV.
        base = cyc + 1;
        start = 1'b1; op = 1'b1; operand_b = 32'd9; eng_lat = 33;
        push(c_k_dst, base, 1'b1);
        push(c_k_idle, base + 10, 1'b0);
        @(negedge clock);
        start = 1'b0;
        run_until(base + 9);
        #2 reset = 1'b0;
        #1 check_all_zero("async_reset_mid_wait");
        run_until(base + 11);
        #2 reset = 1'b1;
        run_until(base + 40);
        eng_lat = -1;

        issue(1'b1, 32'd3, 33, 1'b0, 1'b0);            // DIV after reset recovery

        repeat (3) @(negedge clock);
        #2;
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL pending_events: %0d still queued, expected 0 (next %s at %0d)",
                     sb.size(), kname(sb[0].kind), sb[0].cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
